vga_timing_gen: RTL and testbench

- Source end of the game's pixel-coordinate interface.
- Generates the 10-bit horizontal and vertical pixel counters (hs, vs) that the tictactoe renderer consumes.
- Takes the renderer's colour back, blanks it outside the visible area, and drives the VGA connector with registered colour and sync outputs that are aligned with each other.
- Default timing is 640x480 at 60 Hz on a 25 MHz pixel clock.

---
 rtl/vga_timing_gen_if.sv | 46 ++++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Pixel-coordinate interface between the VGA timing source and the game's
// renderer, plus the registered signals that leave for the VGA connector.
//
// Signals:
//   hs, vs          10-bit horizontal / vertical counters, source -> renderer
//   red_in          3-bit renderer colour for the current (hs,vs)
//   green_in        3-bit renderer colour
//   blue_in         2-bit renderer colour
//   vga_red/green/blue  registered, blanked colour to the DAC
//   hsync, vsync    registered sync outputs
//   video_on        registered active-area flag, aligned with vga_*
//   frame_tick      one-cycle pulse on the last pixel of each frame
//
// Modports:
//   master  timing generator side (drives counters and VGA outputs)
//   slave   renderer / connector side
//
// Handshake: none. The counters free-run; the renderer must return colour
// combinationally for the (hs,vs) presented in the same cycle.
interface vga_timing_gen_if;
    logic [9:0] hs;
    logic [9:0] vs;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;
    logic [2:0] vga_red;
    logic [2:0] vga_green;
    logic [1:0] vga_blue;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_tick;

    modport master (
        output hs, vs, vga_red, vga_green, vga_blue,
               hsync, vsync, video_on, frame_tick,
        input  red_in, green_in, blue_in
    );

    modport slave (
        input  hs, vs, vga_red, vga_green, vga_blue,
               hsync, vsync, video_on, frame_tick,
        output red_in, green_in, blue_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running VGA raster timing generator. Produces the pixel counters for
// the renderer, takes the renderer's colour back, blanks it outside the
// visible area and drives colour, sync, video_on and frame_tick from one
// register stage so every connector-side output lags the counters by
// exactly one cycle. Default timing is 640x480 @ 60 Hz on a 25 MHz clock.
//
// Ports:
//   clk25M  in   pixel clock, the only clock
//   rst     in   asynchronous active-high reset
//   bus     vga_timing_gen_if.master (counters out, colour in, VGA out)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk25M,
    input  logic               rst,
    vga_timing_gen_if.master   bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_hs;
    logic [9:0] r_vs;
    logic [2:0] r_red;
    logic [2:0] r_green;
    logic [1:0] r_blue;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_tick;

    logic w_act;
    logic w_hsync_win;
    logic w_vsync_win;
    logic w_frame_end;

    // All pipeline decisions look at the counters as they stand this cycle;
    // the register stage below then presents them together one cycle later.
    assign w_act       = (r_hs < H_ACT) && (r_vs < V_ACT);
    assign w_hsync_win = (r_hs >= HS_FIRST) && (r_hs <= HS_LAST);
    assign w_vsync_win = (r_vs >= VS_FIRST) && (r_vs <= VS_LAST);
    assign w_frame_end = (r_hs == H_LAST) && (r_vs == V_LAST);

    always_ff @(posedge clk25M or posedge rst) begin
        if (rst) begin
            r_hs         <= '0;
            r_vs         <= '0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video_on   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            if (r_hs == H_LAST) begin
                r_hs <= '0;
                r_vs <= (r_vs == V_LAST) ? '0 : r_vs + 10'd1;
            end else begin
                r_hs <= r_hs + 10'd1;
            end

            // Blank here rather than trusting the renderer to output black.
            r_red        <= w_act ? bus.red_in   : '0;
            r_green      <= w_act ? bus.green_in : '0;
            r_blue       <= w_act ? bus.blue_in  : '0;
            r_video_on   <= w_act;
            r_hsync      <= w_hsync_win ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_vsync_win ? SYNC_POL : ~SYNC_POL;
            r_frame_tick <= w_frame_end;
        end
    end

    assign bus.hs         = r_hs;
    assign bus.vs         = r_vs;
    assign bus.vga_red    = r_red;
    assign bus.vga_green  = r_green;
    assign bus.vga_blue   = r_blue;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.video_on   = r_video_on;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Two instances: "a" with the default
// 640x480 timing (line-level behaviour) and "b" with a tiny 15x8 raster and
// active-high sync so whole frames, vertical sync and frame_tick fit in a
// short run.
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk25M = 1'b0;
    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;

    always #20 clk25M = ~clk25M;

    // ---------------- DUTs and renderers ----------------
    vga_timing_gen_if bus_a ();
    vga_timing_gen_if bus_b ();

    // Renderer a: constant full-white, exercises blanking.
    assign bus_a.red_in   = 3'd7;
    assign bus_a.green_in = 3'd7;
    assign bus_a.blue_in  = 2'd3;

    // Renderer b: colour depends on the coordinates, exercises alignment.
    assign bus_b.red_in   = bus_b.hs[2:0];
    assign bus_b.green_in = bus_b.vs[2:0] ^ 3'd6;
    assign bus_b.blue_in  = bus_b.hs[1:0];

    vga_timing_gen u_dut_a (
        .clk25M (clk25M),
        .rst    (rst_a),
        .bus    (bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) u_dut_b (
        .clk25M (clk25M),
        .rst    (rst_b),
        .bus    (bus_b)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;   // clock edges since the last reset release
    int phase    = 0;   // 0: first run, 1: after mid-frame reset
    int cnt_hsync_a_low_line0 = 0;
    int cnt_vsync_b_high_f0   = 0;
    int cnt_video_b_f0        = 0;
    int cnt_tick_a            = 0;
    int cnt_tick_b            = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d, phase %0d)", tag, obs, exp, k, phase);
        end
    endtask

    // Expected outputs after edge kk, derived from raster position arithmetic.
    task automatic check_cycle(input int kk);
        int ha, va, pha, pva, hb, vb, phb, pvb;
        bit act_a, act_b;
        ha  = kk % 800;          va  = (kk / 800) % 525;
        pha = (kk - 1) % 800;    pva = ((kk - 1) / 800) % 525;
        hb  = kk % 15;           vb  = (kk / 15) % 8;
        phb = (kk - 1) % 15;     pvb = ((kk - 1) / 15) % 8;
        act_a = (pha < 640) && (pva < 480);
        act_b = (phb < 8) && (pvb < 4);

        chk("a_hs",         bus_a.hs, ha);
        chk("a_vs",         bus_a.vs, va);
        chk("a_red",        bus_a.vga_red,   act_a ? 7 : 0);
        chk("a_green",      bus_a.vga_green, act_a ? 7 : 0);
        chk("a_blue",       bus_a.vga_blue,  act_a ? 3 : 0);
        chk("a_video_on",   bus_a.video_on,  act_a);
        chk("a_hsync",      bus_a.hsync, (pha >= 656 && pha <= 751) ? 0 : 1);
        chk("a_vsync",      bus_a.vsync, (pva >= 490 && pva <= 491) ? 0 : 1);
        chk("a_frame_tick", bus_a.frame_tick, (pha == 799 && pva == 524));

        chk("b_hs",         bus_b.hs, hb);
        chk("b_vs",         bus_b.vs, vb);
        chk("b_red",        bus_b.vga_red,   act_b ? (phb & 7) : 0);
        chk("b_green",      bus_b.vga_green, act_b ? ((pvb & 7) ^ 6) : 0);
        chk("b_blue",       bus_b.vga_blue,  act_b ? (phb & 3) : 0);
        chk("b_video_on",   bus_b.video_on,  act_b);
        chk("b_hsync",      bus_b.hsync, (phb >= 10 && phb <= 12) ? 1 : 0);
        chk("b_vsync",      bus_b.vsync, (pvb >= 5 && pvb <= 6) ? 1 : 0);
        chk("b_frame_tick", bus_b.frame_tick, (phb == 14 && pvb == 7));

        if (phase == 0) begin
            if (kk <= 800 && bus_a.hsync == 1'b0) cnt_hsync_a_low_line0++;
            if (kk <= 120 && bus_b.vsync == 1'b1) cnt_vsync_b_high_f0++;
            if (kk <= 120 && bus_b.video_on == 1'b1) cnt_video_b_f0++;
            if (bus_a.frame_tick == 1'b1) cnt_tick_a++;
            if (bus_b.frame_tick == 1'b1) cnt_tick_b++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock and sample on the following falling edge.
    task automatic step();
        @(negedge clk25M);
        k++;
        check_cycle(k);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a_hs"},    bus_a.hs, 0);
        chk({tag, "_a_vs"},    bus_a.vs, 0);
        chk({tag, "_a_red"},   bus_a.vga_red, 0);
        chk({tag, "_a_green"}, bus_a.vga_green, 0);
        chk({tag, "_a_blue"},  bus_a.vga_blue, 0);
        chk({tag, "_a_video"}, bus_a.video_on, 0);
        chk({tag, "_a_tick"},  bus_a.frame_tick, 0);
        chk({tag, "_a_hsync"}, bus_a.hsync, 1);
        chk({tag, "_a_vsync"}, bus_a.vsync, 1);
        chk({tag, "_b_hs"},    bus_b.hs, 0);
        chk({tag, "_b_vs"},    bus_b.vs, 0);
        chk({tag, "_b_red"},   bus_b.vga_red, 0);
        chk({tag, "_b_green"}, bus_b.vga_green, 0);
        chk({tag, "_b_video"}, bus_b.video_on, 0);
        chk({tag, "_b_tick"},  bus_b.frame_tick, 0);
        chk({tag, "_b_hsync"}, bus_b.hsync, 0);
        chk({tag, "_b_vsync"}, bus_b.vsync, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (3) @(negedge clk25M);
        check_reset("rst");

        // Release away from the edge, then free-run two+ default lines and
        // fourteen small frames.
        rst_a = 1'b0;
        rst_b = 1'b0;
        k     = 0;
        for (int i = 0; i < 1700; i++) step();

        chk("a_hsync_low_cycles_line0", cnt_hsync_a_low_line0, 96);
        chk("b_vsync_cycles_frame0",    cnt_vsync_b_high_f0,   30);
        chk("b_active_pixels_frame0",   cnt_video_b_f0,        32);
        chk("b_frame_tick_count",       cnt_tick_b,            14);
        chk("a_frame_tick_count",       cnt_tick_a,            0);

        // Move instance b to raster position (5,2), bounded.
        for (int i = 0; i < 200; i++) begin
            if ((k % 15) == 5 && ((k / 15) % 8) == 2) break;
            step();
        end
        chk("seek_b_pos", ((k % 15) == 5 && ((k / 15) % 8) == 2), 1);
        chk("pre_rst_b_video", bus_b.video_on, 1);

        // Mid-cycle asynchronous reset: outputs must clear before any edge.
        phase = 1;
        #5;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check_reset("async_rst");
        repeat (2) @(negedge clk25M);
        check_reset("held_rst");

        // Release and check counting restarts from (0,0), through one small
        // frame boundary.
        rst_a = 1'b0;
        rst_b = 1'b0;
        k     = 0;
        for (int i = 0; i < 130; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
